// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache with zero-latency hits.
// A miss stalls the fetch port and refills the whole line, one word per read,
// over an Avalon-MM-style master port.
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   cache_addr/rd/data/waitrequest fetch-side responder port (data, waitrequest combinational)
//   flush                          single-cycle pulse, invalidates every line
//   mem_addr/rd/data/waitrequest   refill master port (mem_addr, mem_rd registered)
//   hit_count, miss_count          free-running 32-bit performance counters
module icache_dm #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_LINES      = 64,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cache_addr,
  input  logic                  cache_rd,
  output logic [DATA_WIDTH-1:0] cache_data,
  output logic                  cache_waitrequest,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_waitrequest,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int unsigned OB = $clog2(WORDS_PER_LINE);
  localparam int unsigned IB = $clog2(NUM_LINES);
  localparam int unsigned TW = ADDR_WIDTH - 2 - OB - IB;
  localparam int unsigned LW = ADDR_WIDTH - 2 - OB;   // line number width (index + tag)

  typedef enum logic {IDLE, FILL} state_e;

  state_e                  state_q;
  logic [NUM_LINES-1:0]    valid_q;
  logic [OB-1:0]           word_cnt_q;
  logic                    flush_pending_q;
  logic [LW-1:0]           line_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    mem_rd_q;
  logic [31:0]             hit_count_q;
  logic [31:0]             miss_count_q;

  logic [TW-1:0]           tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0]   data_mem [NUM_LINES][WORDS_PER_LINE];

  // Request address fields
  logic [OB-1:0]           req_off;
  logic [IB-1:0]           req_idx;
  logic [TW-1:0]           req_tag;
  logic [LW-1:0]           req_line;
  logic                    unused_addr_lsbs;

  assign req_off          = cache_addr[2+OB-1:2];
  assign req_idx          = cache_addr[2+OB+IB-1:2+OB];
  assign req_tag          = cache_addr[ADDR_WIDTH-1 -: TW];
  assign req_line         = cache_addr[ADDR_WIDTH-1:2+OB];
  assign unused_addr_lsbs = ^cache_addr[1:0];

  // Line being refilled, taken from the latched miss address
  logic [IB-1:0]           fill_idx;
  logic [TW-1:0]           fill_tag;
  logic                    fill_hs;
  logic                    fill_last;

  assign fill_idx  = line_q[IB-1:0];
  assign fill_tag  = line_q[LW-1 -: TW];
  assign fill_hs   = (state_q == FILL) && mem_rd_q && !mem_waitrequest;
  assign fill_last = (word_cnt_q == OB'(WORDS_PER_LINE - 1));

  // Combinational lookup: hits answer in the same cycle the address appears
  logic hit_c;
  always_comb begin
    hit_c             = 1'b0;
    cache_waitrequest = 1'b0;
    cache_data        = '0;
    if (state_q == IDLE) begin
      hit_c             = cache_rd && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
      cache_waitrequest = cache_rd && !hit_c;
      if (hit_c) cache_data = data_mem[req_idx][req_off];
    end else begin
      cache_waitrequest = 1'b1;
    end
  end

  // Control FSM, valid bits and counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      word_cnt_q      <= '0;
      flush_pending_q <= 1'b0;
      line_q          <= '0;
      mem_addr_q      <= '0;
      mem_rd_q        <= 1'b0;
      hit_count_q     <= '0;
      miss_count_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) valid_q <= '0;
          if (hit_c) hit_count_q <= hit_count_q + 32'd1;
          if (cache_rd && !hit_c) begin
            line_q          <= req_line;
            mem_addr_q      <= {req_line, (2+OB)'(0)};
            mem_rd_q        <= 1'b1;
            word_cnt_q      <= '0;
            valid_q[req_idx] <= 1'b0;
            miss_count_q    <= miss_count_q + 32'd1;
            state_q         <= FILL;
          end
        end
        FILL: begin
          if (flush) flush_pending_q <= 1'b1;
          if (fill_hs) begin
            word_cnt_q <= word_cnt_q + OB'(1);
            if (fill_last) begin
              mem_rd_q        <= 1'b0;
              flush_pending_q <= 1'b0;
              state_q         <= IDLE;
              // A flush seen anywhere in the fill also kills the new line
              if (flush_pending_q || flush) valid_q <= '0;
              else                          valid_q[fill_idx] <= 1'b1;
            end else begin
              mem_addr_q <= mem_addr_q + ADDR_WIDTH'(4);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them
  always_ff @(posedge clock) begin
    if (fill_hs) begin
      data_mem[fill_idx][word_cnt_q] <= mem_data;
      if (fill_last) tag_mem[fill_idx] <= fill_tag;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed, table-driven bench for icache_dm with a zero-wait
// memory model (data = addr ^ 32'hA5A50000) and optional injected stalls.
module tb_icache_dm;

  logic        clock;
  logic        reset_n;
  logic [31:0] cache_addr;
  logic        cache_rd;
  logic [31:0] cache_data;
  logic        cache_waitrequest;
  logic        flush;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data;
  logic        mem_waitrequest;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_dm #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_LINES(64), .WORDS_PER_LINE(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cache_addr(cache_addr), .cache_rd(cache_rd), .cache_data(cache_data),
    .cache_waitrequest(cache_waitrequest), .flush(flush),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_waitrequest(mem_waitrequest),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model with a stall budget applied to one chosen word address
  int          stall_used;
  int          stall_base;
  int          stall_budget;
  logic [31:0] stall_addr;

  assign mem_data        = mem_addr ^ 32'hA5A50000;
  assign mem_waitrequest = mem_rd && (mem_addr == stall_addr) &&
                           ((stall_used - stall_base) < stall_budget);

  initial stall_used = 0;
  always @(posedge clock) if (mem_waitrequest) stall_used <= stall_used + 1;

  // Log of refill handshakes and stalled cycles, sampled mid-cycle
  logic [31:0] hs_q[$];
  logic [31:0] stall_q[$];
  always @(negedge clock) begin
    if (mem_rd && !mem_waitrequest) hs_q.push_back(mem_addr);
    if (mem_rd && mem_waitrequest)  stall_q.push_back(mem_addr);
  end

  int checks;
  int failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          flush_at;   // request cycle in which flush pulses, -1 = none
    int          stall_n;    // stall cycles injected on word 2 of the refill
    int          exp_wait;
    logic [31:0] exp_data;
    int          exp_hs;
    int          exp_hits;
    int          exp_miss;
  } vec_t;

  vec_t vecs[12];

  // Issue one fetch, held until waitrequest drops; entered/left at posedge+1
  task automatic run_vec(input vec_t v, input int id);
    int          waits;
    bit          done;
    logic [31:0] data;
    logic [31:0] base;
    base = {v.addr[31:4], 4'h0};
    hs_q.delete();
    stall_q.delete();
    stall_addr   = base + 32'h8;
    stall_base   = stall_used;
    stall_budget = v.stall_n;
    cache_addr   = v.addr;
    cache_rd     = 1'b1;
    waits = 0;
    done  = 1'b0;
    data  = '0;
    for (int n = 0; n < 64 && !done; n++) begin
      flush = (n == v.flush_at);
      @(negedge clock);
      if (!cache_waitrequest) begin
        data = cache_data;
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clock);
      #1;
    end
    flush = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL v%0d timeout waiting for waitrequest low", id);
    end
    chk($sformatf("v%0d wait_cycles", id), 32'(waits), 32'(v.exp_wait));
    chk($sformatf("v%0d data", id), data, v.exp_data);
    chk($sformatf("v%0d mem_reads", id), 32'(hs_q.size()), 32'(v.exp_hs));
    chk($sformatf("v%0d hit_count", id), hit_count, 32'(v.exp_hits));
    chk($sformatf("v%0d miss_count", id), miss_count, 32'(v.exp_miss));
    for (int k = 0; k < hs_q.size(); k++)
      chk($sformatf("v%0d mem_addr[%0d]", id, k), hs_q[k], base + 32'(4 * (k % 4)));
    chk($sformatf("v%0d stall_cycles", id), 32'(stall_q.size()), 32'(v.stall_n));
    for (int k = 0; k < stall_q.size(); k++)
      chk($sformatf("v%0d stall_addr[%0d]", id, k), stall_q[k], stall_addr);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    stall_base   = 0;
    stall_budget = 0;
    stall_addr   = 32'hFFFF_FFFF;
    reset_n      = 1'b0;
    cache_addr   = '0;
    cache_rd     = 1'b0;
    flush        = 1'b0;

    //             addr          flush stall wait data          hs hits miss
    vecs[0]  = '{32'h0000_0104, -1, 0,  5, 32'hA5A5_0104, 4,  1, 1}; // cold miss
    vecs[1]  = '{32'h0000_0100, -1, 0,  0, 32'hA5A5_0100, 0,  2, 1}; // hits
    vecs[2]  = '{32'h0000_0104, -1, 0,  0, 32'hA5A5_0104, 0,  3, 1};
    vecs[3]  = '{32'h0000_0108, -1, 0,  0, 32'hA5A5_0108, 0,  4, 1};
    vecs[4]  = '{32'h0000_010C, -1, 0,  0, 32'hA5A5_010C, 0,  5, 1};
    vecs[5]  = '{32'h0000_0504, -1, 0,  5, 32'hA5A5_0504, 4,  6, 2}; // conflict
    vecs[6]  = '{32'h0000_0104, -1, 0,  5, 32'hA5A5_0104, 4,  7, 3}; // evicted
    vecs[7]  = '{32'h0000_0200, -1, 3,  8, 32'hA5A5_0200, 4,  8, 4}; // stalls
    vecs[8]  = '{32'h0000_0104,  0, 0,  0, 32'hA5A5_0104, 0,  9, 4}; // flush, pre-flush hit
    vecs[9]  = '{32'h0000_0104, -1, 0,  5, 32'hA5A5_0104, 4, 10, 5}; // flushed
    vecs[10] = '{32'h0000_0300,  2, 0, 10, 32'hA5A5_0300, 8, 11, 7}; // flush mid-fill
    vecs[11] = '{32'h0000_0300, -1, 0,  0, 32'hA5A5_0300, 0, 12, 7};

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("reset mem_rd", 32'(mem_rd), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset hit_count", hit_count, 32'd0);
    chk("reset miss_count", miss_count, 32'd0);
    chk("idle waitrequest", 32'(cache_waitrequest), 32'd0);
    chk("idle data", cache_data, 32'd0);
    cache_addr = 32'h104;
    cache_rd   = 1'b1;
    #1;
    chk("cold waitrequest", 32'(cache_waitrequest), 32'd1);
    chk("cold data", cache_data, 32'd0);
    cache_rd = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset in the middle of a refill of 0x404: after word 1 handshakes
    cache_addr = 32'h404;
    cache_rd   = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("midfill mem_rd before reset", 32'(mem_rd), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midfill mem_rd", 32'(mem_rd), 32'd0);
    chk("midfill hit_count", hit_count, 32'd0);
    chk("midfill miss_count", miss_count, 32'd0);
    chk("midfill waitrequest", 32'(cache_waitrequest), 32'd1);
    cache_rd = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    run_vec('{32'h0000_0404, -1, 0, 5, 32'hA5A5_0404, 4, 1, 1}, 12);
    cache_rd = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache; the responder on the instruction-fetch cache port (addr/rd/data/waitrequest).
- Sits between the fetch stage and the memory interconnect.
- On a miss it holds off the fetch stage with waitrequest and refills the whole line from memory, one word per read, over a simple Avalon-MM-style master port.
- Provides a whole-cache flush and hit/miss performance counters.

Parameters:
- ADDR_WIDTH, 32, byte address width on both ports.
- DATA_WIDTH, 32, word width; fixed at 32.
- NUM_LINES, 64, number of cache lines; power of 2, >= 2.
- WORDS_PER_LINE, 4, words per line; power of 2, >= 2.

Ports:
- clock  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- cache_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- cache_rd  in  1  fetch read request.
- cache_data  out  DATA_WIDTH  instruction word.
- cache_waitrequest  out  1  high = response not ready; requester holds cache_addr.
- flush  in  1  single-cycle pulse; invalidate all lines.
- mem_addr  out  ADDR_WIDTH  refill word address, word-aligned.
- mem_rd  out  1  refill read request.
- mem_data  in  DATA_WIDTH  refill data; valid in the cycle mem_rd=1 and mem_waitrequest=0.
- mem_waitrequest  in  1  memory stall.
- hit_count  out  32  hits counted; wraps at 2^32.
- miss_count  out  32  misses counted (fill starts); wraps at 2^32.

Behaviour:
- Address split, with OB=log2(WORDS_PER_LINE), IB=log2(NUM_LINES):
  - word offset = addr[2+OB-1:2]
  - index = addr[2+OB+IB-1:2+OB]
  - tag = remaining upper bits.
- State: valid[NUM_LINES], tag array, data array of NUM_LINES x WORDS_PER_LINE words. The data array is read combinationally.
- FSM has two states, IDLE and FILL; word_cnt is OB bits wide.
- IDLE:
  - hit = cache_rd & valid[index] & (tag match).
  - cache_waitrequest = cache_rd & ~hit, combinational.
  - cache_data = selected word on hit, else 0.
  - Zero-latency hit: data is valid in the same cycle the address is presented.
  - On cache_rd & ~hit: latch the line base address, clear valid[index], word_cnt=0, miss_count+1, go to FILL.
  - Each hit cycle: hit_count+1.
  - cache_rd=0: cache_waitrequest=0, cache_data=0, no count.
- FILL:
  - cache_waitrequest=1 unconditionally; cache_data=0.
  - mem_rd=1, mem_addr = line_base + 4*word_cnt.
  - Handshake = mem_rd & ~mem_waitrequest. On handshake: write mem_data to data[index][word_cnt], word_cnt+1.
  - mem_rd and mem_addr are held stable while mem_waitrequest=1.
  - Handshake with word_cnt==WORDS_PER_LINE-1: write tag, set valid[index] (unless flush_pending), mem_rd=0 the next cycle, go to IDLE.
  - The next IDLE cycle re-looks up the address and hits.
- Miss timing with zero-wait memory: cache_waitrequest is high for 1+WORDS_PER_LINE cycles, and data is delivered in the following cycle. Each memory stall cycle adds one cycle.
- Requester rule: cache_addr and cache_rd must be held while cache_waitrequest=1. Behaviour is unspecified if this is violated.
- Flush:
  - In IDLE: all valid bits clear at the clock edge. In the same cycle, lookup uses the pre-flush valid bits.
  - In FILL: sets flush_pending. The fill runs to completion, but all valids, including the filled line, clear at fill end; flush_pending then clears.
  - Flush in the fill's final handshake cycle behaves the same way.
- Reset values:
  - All valid bits=0, FSM=IDLE, word_cnt=0, flush_pending=0.
  - mem_rd=0, mem_addr=0, hit_count=0, miss_count=0.
  - cache_waitrequest=cache_rd (cold miss); cache_data=0.
- Reset mid-fill: mem_rd drops immediately (async), and the partial line stays invalid.
- Tag and data arrays are not reset.

Test Plan:
Setup for all scenarios: NUM_LINES=64, WORDS_PER_LINE=4, and a zero-wait memory model returning addr^32'hA5A50000.
1. Cold miss: after reset, cache_rd=1, addr 0x104.
   - waitrequest is high for 5 cycles, and mem_addr steps 0x100, 0x104, 0x108, 0x10C.
   - Cycle 6: waitrequest=0, data=0xA5A50104, miss_count=1.
2. Hit: after scenario 1, addrs 0x100..0x10C back-to-back.
   - waitrequest=0 every cycle with correct data, and hit_count increments by 4.
3. Memory stalls: mem_waitrequest high for 3 cycles on word 2 during a miss at 0x200.
   - mem_addr is held at 0x208 through the stall, total miss waitrequest is 8 cycles, and the data is correct.
4. Conflict: fill 0x104, then read 0x504 (same index 0x10, different tag).
   - Read of 0x504: miss, refill from 0x500.
   - Re-read of 0x104: misses again, miss_count=3.
5. Flush:
   - Flush in IDLE: the next read of 0x104 misses.
   - Flush during the 2nd word of a fill: the fill completes (4 mem reads), and the post-fill lookup misses and refills again.
6. Reset mid-fill: reset_n low after word 1 of a fill.
   - mem_rd=0 immediately, and the counters read 0.
   - After release, a read of the same address performs a full 4-word refill.
